// File: rtl/operador.sv
// Registered two-operand ALU slice: ADD/SUB/AND/OR with zero, carry and
// overflow flags, all available one clock after the operands.
module operador #(
  parameter int NB_DATA = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_dataA,
  input  logic [NB_DATA-1:0] i_dataB,
  input  logic [1:0]         i_sel,
  output logic [NB_DATA-1:0] o_dataC,
  output logic               o_zero,
  output logic               o_carry,
  output logic               o_overflow
);

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_AND = 2'b10;
  localparam logic [1:0] SEL_OR  = 2'b11;

  logic [NB_DATA:0]   w_sum;
  logic [NB_DATA:0]   w_diff;
  logic [NB_DATA-1:0] w_res;
  logic               w_carry;
  logic               w_ovf;
  logic               w_msb_a;
  logic               w_msb_b;

  assign w_sum   = {1'b0, i_dataA} + {1'b0, i_dataB};
  // Extended-width subtraction: the top bit is the unsigned borrow (A < B).
  assign w_diff  = {1'b0, i_dataA} - {1'b0, i_dataB};
  assign w_msb_a = i_dataA[NB_DATA-1];
  assign w_msb_b = i_dataB[NB_DATA-1];

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    unique case (i_sel)
      SEL_ADD: begin
        w_res   = w_sum[NB_DATA-1:0];
        w_carry = w_sum[NB_DATA];
        w_ovf   = (w_msb_a == w_msb_b) &&
                  (w_sum[NB_DATA-1] != w_msb_a);
      end
      SEL_SUB: begin
        w_res   = w_diff[NB_DATA-1:0];
        w_carry = w_diff[NB_DATA];
        w_ovf   = (w_msb_a != w_msb_b) &&
                  (w_diff[NB_DATA-1] != w_msb_a);
      end
      SEL_AND: w_res = i_dataA & i_dataB;
      SEL_OR:  w_res = i_dataA | i_dataB;
      default: w_res = '0;
    endcase
  end

  logic [NB_DATA-1:0] r_dataC;
  logic               r_zero;
  logic               r_carry;
  logic               r_ovf;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dataC <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_dataC <= w_res;
      r_zero  <= (w_res == '0);
      r_carry <= w_carry;
      r_ovf   <= w_ovf;
    end
  end

  assign o_dataC    = r_dataC;
  assign o_zero     = r_zero;
  assign o_carry    = r_carry;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_operador.sv
// Bench for operador: directed vector table, reset sequences and
// randomized traffic against an arithmetic reference model.
module tb_operador;

  logic        i_clk;
  logic        i_rst;
  logic [15:0] i_dataA;
  logic [15:0] i_dataB;
  logic [1:0]  i_sel;
  logic [15:0] o_dataC;
  logic        o_zero;
  logic        o_carry;
  logic        o_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  operador #(.NB_DATA(16)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_dataA    (i_dataA),
    .i_dataB    (i_dataB),
    .i_sel      (i_sel),
    .o_dataC    (o_dataC),
    .o_zero     (o_zero),
    .o_carry    (o_carry),
    .o_overflow (o_overflow)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic        z;
    logic        cy;
    logic        ov;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [15:0] c,
                       input logic z, input logic cy, input logic ov);
    n_checks++;
    if (o_dataC !== c || o_zero !== z || o_carry !== cy ||
        o_overflow !== ov) begin
      n_fail++;
      $display("FAIL %s: got C=%h z=%b c=%b v=%b, want C=%h z=%b c=%b v=%b",
               name, o_dataC, o_zero, o_carry, o_overflow, c, z, cy, ov);
    end
  endtask

  task automatic apply(input logic [1:0] sel, input logic [15:0] a,
                       input logic [15:0] b);
    @(negedge i_clk);
    i_sel   = sel;
    i_dataA = a;
    i_dataB = b;
    @(posedge i_clk);
    #1;
  endtask

  function automatic int sval(input logic [15:0] v);
    return v[15] ? int'(v) - 65536 : int'(v);
  endfunction

  // Reference: plain integer arithmetic, flags from numeric range checks.
  function automatic logic [18:0] model(input logic [1:0] sel,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    int u, s;
    logic [15:0] c;
    logic cy, ov;
    cy = 1'b0;
    ov = 1'b0;
    case (sel)
      2'd0: begin
        u  = int'(a) + int'(b);
        s  = sval(a) + sval(b);
        c  = 16'(u % 65536);
        cy = (u > 65535);
        ov = (s > 32767) || (s < -32768);
      end
      2'd1: begin
        u  = int'(a) - int'(b);
        s  = sval(a) - sval(b);
        c  = 16'((u + 65536) % 65536);
        cy = (a < b);
        ov = (s > 32767) || (s < -32768);
      end
      2'd2: c = a & b;
      default: c = a | b;
    endcase
    return {c, (c == 16'd0), cy, ov};
  endfunction

  initial begin
    logic [18:0] exp;
    vecs[0]  = '{2'd0, 16'd6,    16'd4,    16'd10,   1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'd1, 16'd6,    16'd4,    16'd2,    1'b0, 1'b0, 1'b0};
    vecs[2]  = '{2'd2, 16'd6,    16'd4,    16'd4,    1'b0, 1'b0, 1'b0};
    vecs[3]  = '{2'd3, 16'd6,    16'd4,    16'd6,    1'b0, 1'b0, 1'b0};
    vecs[4]  = '{2'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{2'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{2'd1, 16'd4,    16'd6,    16'hFFFE, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{2'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{2'd2, 16'h00F0, 16'h000F, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{2'd3, 16'h00F0, 16'h000F, 16'h00FF, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};

    i_rst   = 1'b1;
    i_sel   = 2'd3;
    i_dataA = 16'hFFFF;
    i_dataB = 16'h1234;
    #1;
    check("reset_t0", 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge i_clk);
      i_dataA = ~i_dataA;
      i_sel   = i_sel + 2'd1;
      @(posedge i_clk);
      #1;
      check("reset_hold", 16'h0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge i_clk);
    i_rst   = 1'b0;
    i_sel   = 2'd0;
    i_dataA = 16'd3;
    i_dataB = 16'd5;
    #1;
    check("release_no_edge", 16'h0, 1'b0, 1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    check("first_edge", 16'd8, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].sel, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d", i), vecs[i].c, vecs[i].z,
            vecs[i].cy, vecs[i].ov);
    end

    apply(2'd0, 16'hFFFF, 16'h0001);
    check("pre_midreset", 16'h0, 1'b1, 1'b1, 1'b0);
    #1;
    i_rst = 1'b1;
    #1;
    check("midreset_async", 16'h0, 1'b0, 1'b0, 1'b0);
    apply(2'd0, 16'h7FFF, 16'h0001);
    check("midreset_hold", 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b0;
    apply(2'd3, 16'h1200, 16'h0034);
    check("post_midreset", 16'h1234, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [1:0]  s;
      logic [15:0] a, b;
      s = 2'($urandom_range(0, 3));
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 8 == 0) b = a;
      if (i % 8 == 1) a = 16'h8000 ^ 16'($urandom_range(0, 3));
      apply(s, a, b);
      exp = model(s, a, b);
      check($sformatf("rand%0d", i), exp[18:3], exp[2], exp[1], exp[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
